// File: rtl/aes_pkg.sv
// Shared constants and state encoding for the AES round sequencing logic.
// Imported by the controller, its bus interface and the bench.
package aes_pkg;

    localparam int AES_BLOCK_W    = 128;
    localparam int AES_ROUNDS_128 = 10;
    localparam int RIDX_W         = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        ROUND   = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Request, response and datapath-control signals of the AES round controller.
// slave is the controller side; master is the request source/datapath side.
interface aes_round_ctrl_if
    import aes_pkg::*;
#(
    parameter int BLOCK_W = AES_BLOCK_W
) ();

    logic               i_valid;
    logic               o_ready;
    logic [BLOCK_W-1:0] i_plain;
    logic [BLOCK_W-1:0] i_key;
    logic               o_valid;
    logic               i_ready;
    logic [BLOCK_W-1:0] o_cipher;
    logic               o_dp_load;
    logic               o_dp_round_en;
    logic [RIDX_W-1:0]  o_dp_round_idx;
    logic               o_dp_final;
    logic [BLOCK_W-1:0] o_dp_state_in;
    logic [BLOCK_W-1:0] o_dp_key_in;
    logic [BLOCK_W-1:0] i_dp_state;
    logic               o_busy;

    modport slave (
        input  i_valid, i_plain, i_key, i_ready, i_dp_state,
        output o_ready, o_valid, o_cipher, o_dp_load,
        output o_dp_round_en, o_dp_round_idx, o_dp_final,
        output o_dp_state_in, o_dp_key_in, o_busy
    );

    modport master (
        output i_valid, i_plain, i_key, i_ready, i_dp_state,
        input  o_ready, o_valid, o_cipher, o_dp_load,
        input  o_dp_round_en, o_dp_round_idx, o_dp_final,
        input  o_dp_state_in, o_dp_key_in, o_busy
    );

endinterface

// File: rtl/aes_round_ctrl.sv
// Sequencer for an iterative one-round-per-cycle AES datapath: accept,
// initial key add, ROUNDS round steps, capture, then hold result until taken.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int ROUNDS  = AES_ROUNDS_128,
    parameter int BLOCK_W = AES_BLOCK_W
) (
    input logic              i_clock,
    input logic              i_reset,
    aes_round_ctrl_if.slave  bus
);

    localparam logic [RIDX_W-1:0] LAST = RIDX_W'(ROUNDS);
    localparam logic [RIDX_W-1:0] ONE  = RIDX_W'(1);

    generate
        if (ROUNDS < 1 || ROUNDS > 15) begin : g_bad_rounds
            $error("aes_round_ctrl: ROUNDS must be within 1..15");
        end
    endgenerate

    state_t             state;
    logic               valid;
    logic               load;
    logic               round_en;
    logic [RIDX_W-1:0]  round_idx;
    logic               final_rnd;
    logic               busy;
    logic [BLOCK_W-1:0] cipher;
    logic [BLOCK_W-1:0] plain_q;
    logic [BLOCK_W-1:0] key_q;

    // round_idx doubles as the round counter; it is only nonzero in ROUND
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state     <= IDLE;
            valid     <= 1'b0;
            load      <= 1'b0;
            round_en  <= 1'b0;
            round_idx <= '0;
            final_rnd <= 1'b0;
            busy      <= 1'b0;
            cipher    <= '0;
            plain_q   <= '0;
            key_q     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.i_valid) begin
                        plain_q <= bus.i_plain;
                        key_q   <= bus.i_key;
                        load    <= 1'b1;
                        busy    <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    load      <= 1'b0;
                    round_en  <= 1'b1;
                    round_idx <= ONE;
                    final_rnd <= (LAST == ONE);
                    state     <= ROUND;
                end
                ROUND: begin
                    if (round_idx == LAST) begin
                        round_en  <= 1'b0;
                        round_idx <= '0;
                        final_rnd <= 1'b0;
                        state     <= CAPTURE;
                    end else begin
                        round_idx <= round_idx + ONE;
                        final_rnd <= ((round_idx + ONE) == LAST);
                    end
                end
                CAPTURE: begin
                    cipher <= bus.i_dp_state;
                    valid  <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    if (bus.i_ready) begin
                        valid <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_ready        = (state == IDLE);
    assign bus.o_valid        = valid;
    assign bus.o_cipher       = cipher;
    assign bus.o_dp_load      = load;
    assign bus.o_dp_round_en  = round_en;
    assign bus.o_dp_round_idx = round_idx;
    assign bus.o_dp_final     = final_rnd;
    assign bus.o_dp_state_in  = plain_q;
    assign bus.o_dp_key_in    = key_q;
    assign bus.o_busy         = busy;

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
Sequencing controller for an iterative single-round AES-128 datapath.
- Accepts a plaintext/key pair over a valid/ready handshake and holds both operands.
- Drives the datapath through the initial AddRoundKey load and ROUNDS round steps, flagging the final round.
- Captures the ciphertext and presents it downstream over a second valid/ready handshake.
- Sits between the encryption request source and the round datapath/key-expansion unit inside aes_top.

Parameters:
ROUNDS, 10, number of round steps after the initial load (10/12/14 for AES-128/192/256); legal range 1..15.
BLOCK_W, 128, data and key width in bits.

Ports:
i_clock  input  1  system clock, rising edge
i_reset  input  1  synchronous, active-high reset
i_valid  input  1  upstream request valid
o_ready  output  1  controller can accept a request
i_plain  input  BLOCK_W  plaintext, big-endian [0:127] bit order
i_key  input  BLOCK_W  cipher key, [0:127] bit order
o_valid  output  1  ciphertext valid
i_ready  input  1  downstream accepts ciphertext
o_cipher  output  BLOCK_W  captured ciphertext
o_dp_load  output  1  datapath loads o_dp_state_in XOR o_dp_key_in; key unit loads o_dp_key_in
o_dp_round_en  output  1  datapath executes one round this cycle
o_dp_round_idx  output  4  current round number, 1..ROUNDS; 0 otherwise
o_dp_final  output  1  final round: datapath skips MixColumns
o_dp_state_in  output  BLOCK_W  registered plaintext
o_dp_key_in  output  BLOCK_W  registered key
i_dp_state  input  BLOCK_W  datapath state register, result of the previous cycle's operation
o_busy  output  1  high in every state except IDLE

Behaviour:
- States: IDLE, LOAD, ROUND, CAPTURE, DONE.
- Reset values:
  - State is IDLE.
  - o_valid, o_dp_load, o_dp_round_en, o_dp_final, o_busy are 0.
  - o_dp_round_idx is 0.
  - o_cipher, o_dp_state_in, o_dp_key_in are all zero.
  - o_ready is 1 in the first cycle after reset.
- o_ready = (state == IDLE), decoded combinationally from state.
- IDLE:
  - Accept when i_valid & o_ready.
  - At that edge, register i_plain and i_key; go to LOAD.
  - Inputs are sampled only at the accepting edge.
- LOAD: o_dp_load = 1 for exactly one cycle; round counter is set to 1; go to ROUND.
- ROUND:
  - o_dp_round_en = 1 and o_dp_round_idx = counter.
  - o_dp_final = (counter == ROUNDS).
  - Counter increments each cycle.
  - After the cycle with counter == ROUNDS, go to CAPTURE. The counter does not wrap.
- CAPTURE: o_cipher <= i_dp_state (the final-round result); go to DONE.
- DONE:
  - o_valid = 1, with o_cipher stable.
  - Hold while i_ready = 0.
  - On i_ready = 1, go to IDLE. o_valid drops the next cycle.
- Latency (accept edge at end of cycle 0):
  - LOAD in cycle 1.
  - ROUND in cycles 2..ROUNDS+1.
  - CAPTURE in cycle ROUNDS+2.
  - o_valid from cycle ROUNDS+3 (cycle 13 for ROUNDS = 10).
- Throughput: minimum ROUNDS+4 cycles per block with i_ready held high.
- i_valid while busy is ignored. No queueing; the request is not lost because o_ready = 0 holds the upstream.
- o_dp_load, o_dp_round_en and o_dp_final are never asserted together. o_dp_final is 0 outside ROUND.
- i_reset in any state (including mid-ROUND or DONE with i_ready = 0) returns to IDLE next cycle with reset values. The in-flight block is discarded and no o_valid pulse is produced.
- i_reset has priority over every handshake in the same cycle.
- o_dp_state_in and o_dp_key_in hold the accepted operands until the next accept.

Decomposition:
- Shared package aes_pkg: state encoding constants (IDLE = 0, LOAD = 1, ROUND = 2, CAPTURE = 3, DONE = 4), AES_BLOCK_W = 128, AES_ROUNDS_128 = 10, round-index width 4.
- Single module. The round counter and FSM are inline; no sub-module is warranted.
- Elaboration-time check: ROUNDS within 1..15.

Test Plan:
- FIPS-197 vector with a behavioural round datapath model:
  - Stimulus: i_plain 3243f6a8885a308d313198a2e0370734, i_key 2b7e151628aed2a6abf7158809cf4f3c.
  - Required response: o_cipher 3925841d02dc09fbdc118597196a0b32, o_valid rising in cycle 13 after accept.
- Sequence check:
  - Stimulus: any single request.
  - Required response: o_dp_load high exactly in cycle 1; o_dp_round_idx 1,2,...,10 in cycles 2..11; o_dp_final high only in cycle 11.
- Backpressure:
  - Stimulus: i_ready held 0 for 20 cycles after o_valid.
  - Required response: o_valid stays 1 with o_cipher unchanged; o_ready stays 0; a second i_valid is not accepted until the cycle after i_ready = 1.
- Back-to-back:
  - Stimulus: two vectors queued with i_valid continuously high and i_ready = 1.
  - Required response: accepts are 14 cycles apart; both ciphertexts are correct and in order.
- Reset mid-operation:
  - Stimulus: assert i_reset during round 5.
  - Required response: next cycle state IDLE, o_ready = 1, o_busy = 0, o_dp_round_idx = 0, o_cipher = 0, and no o_valid pulse.
  - Follow-up: a fresh request then completes correctly.
- Busy ignore:
  - Stimulus: toggle i_valid and change i_plain/i_key during rounds.
  - Required response: o_dp_state_in and o_dp_key_in are unchanged; the output still matches the first accepted vector.
